// File: rtl/adc_pkg.sv
// ----------------------------------------------------------------------------
// adc_pkg
// Shared types and defaults for the XADC sample sequencer: FSM state
// encoding, channel encoding, default DRP addresses, ring-buffer placement
// and the ring-buffer head advance helper.
// ----------------------------------------------------------------------------
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } adc_state_t;

    typedef enum logic {
        CH_EMG = 1'b0,
        CH_ECG = 1'b1
    } adc_ch_t;

    localparam int          HEAD_W        = 10;

    localparam int          DEF_CLK_DIV   = 175000;
    localparam int          DEF_BUF_DEPTH = 640;
    localparam int          DEF_TIMEOUT   = 64;
    localparam logic [11:0] DEF_EMG_BASE  = 12'h100;
    localparam logic [11:0] DEF_ECG_BASE  = 12'h380;
    localparam logic [6:0]  DEF_EMG_DADDR = 7'h13;
    localparam logic [6:0]  DEF_ECG_DADDR = 7'h1B;

    // Advance a ring-buffer head, wrapping after the last slot.
    function automatic logic [HEAD_W-1:0] next_head(input logic [HEAD_W-1:0] head,
                                                    input int depth);
        return (head == HEAD_W'(depth - 1)) ? '0 : head + 1'b1;
    endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// ----------------------------------------------------------------------------
// adc_tick_gen
// Fixed-rate sample tick. The counter runs while enable is high and emits a
// one-cycle tick on its last count, then wraps. Dropping enable parks the
// counter at 0, so a re-enable always yields a full period before the tick.
//
// Ports:
//   clock   in   system clock
//   reset   in   asynchronous, active-high reset
//   enable  in   tick generation enable
//   tick    out  one-cycle pulse every CLK_DIV enabled cycles
// ----------------------------------------------------------------------------
module adc_tick_gen
    import adc_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int               CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!enable || (count == TERM)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = enable && (count == TERM);

endmodule

// File: rtl/adc_sample_sequencer.sv
// ----------------------------------------------------------------------------
// adc_sample_sequencer
// Alternates EMG (VAUX3) and ECG (VAUX11) XADC reads, one DRP read per tick,
// and stores each 12-bit conversion into that channel's ring buffer via the
// data RAM ADC write port. Heads and sticky error flags go to the CPU side.
//
// Ports:
//   clock, reset         system clock, asynchronous active-high reset
//   enable               tick generation enable
//   clear_flags          clears overrun / timeout (a same-cycle set wins)
//   drp_den/dwe/daddr    DRP request (den one-cycle pulse, dwe tied 0)
//   drp_do, drp_drdy     DRP read data / data ready
//   adc_wEn/addr/dataIn  RAM ADC write port (addr/data 0 when wEn=0)
//   emg_head, ecg_head   next slot index of each ring buffer
//   busy                 FSM not IDLE
//   overrun              sticky: tick arrived while busy and was dropped
//   timeout              sticky: drdy not seen within TIMEOUT cycles
//
// state | meaning
// IDLE  | waiting for tick; latch channel and issue request
// REQ   | drp_den high for this single cycle
// WAIT  | waiting for drdy, bounded by TIMEOUT cycles
// WRITE | adc_wEn high for one cycle; head advances, channel toggles
// ----------------------------------------------------------------------------
module adc_sample_sequencer
    import adc_pkg::*;
#(
    parameter int          CLK_DIV   = DEF_CLK_DIV,
    parameter int          BUF_DEPTH = DEF_BUF_DEPTH,
    parameter logic [11:0] EMG_BASE  = DEF_EMG_BASE,
    parameter logic [11:0] ECG_BASE  = DEF_ECG_BASE,
    parameter logic [6:0]  EMG_DADDR = DEF_EMG_DADDR,
    parameter logic [6:0]  ECG_DADDR = DEF_ECG_DADDR,
    parameter int          TIMEOUT   = DEF_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear_flags,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [6:0]  drp_daddr,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        adc_wEn,
    output logic [11:0] adc_addr,
    output logic [31:0] adc_dataIn,
    output logic [9:0]  emg_head,
    output logic [9:0]  ecg_head,
    output logic        busy,
    output logic        overrun,
    output logic        timeout
);

    localparam int              TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    adc_state_t       state;
    adc_ch_t          channel;
    adc_ch_t          cur_ch;
    logic [TMR_W-1:0] timer;
    logic             tick;
    logic             timeout_hit;
    logic             unused_do_bits;

    adc_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    assign drp_dwe        = 1'b0;
    // Low nibble of the status register is below the 12-bit conversion result.
    assign unused_do_bits = ^drp_do[3:0];
    // A drdy on the final wait cycle is still accepted.
    assign timeout_hit    = (state == WAIT) && !drp_drdy && (timer == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            channel    <= CH_EMG;
            cur_ch     <= CH_EMG;
            timer      <= '0;
            drp_den    <= 1'b0;
            drp_daddr  <= '0;
            adc_wEn    <= 1'b0;
            adc_addr   <= '0;
            adc_dataIn <= '0;
            emg_head   <= '0;
            ecg_head   <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        cur_ch    <= channel;
                        drp_daddr <= (channel == CH_EMG) ? EMG_DADDR : ECG_DADDR;
                        drp_den   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= REQ;
                    end
                end

                REQ: begin
                    drp_den <= 1'b0;
                    timer   <= TMR_LOAD;
                    state   <= WAIT;
                end

                WAIT: begin
                    if (drp_drdy) begin
                        adc_wEn    <= 1'b1;
                        adc_addr   <= (cur_ch == CH_EMG) ? (EMG_BASE + 12'(emg_head))
                                                         : (ECG_BASE + 12'(ecg_head));
                        adc_dataIn <= {20'b0, drp_do[15:4]};
                        drp_daddr  <= '0;
                        state      <= WRITE;
                    end else if (timer == '0) begin
                        // Abandon this sample; heads stay put, next tick serves the other channel.
                        drp_daddr <= '0;
                        busy      <= 1'b0;
                        channel   <= (cur_ch == CH_EMG) ? CH_ECG : CH_EMG;
                        state     <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                WRITE: begin
                    adc_wEn    <= 1'b0;
                    adc_addr   <= '0;
                    adc_dataIn <= '0;
                    if (cur_ch == CH_EMG) begin
                        emg_head <= next_head(emg_head, BUF_DEPTH);
                    end else begin
                        ecg_head <= next_head(ecg_head, BUF_DEPTH);
                    end
                    channel <= (cur_ch == CH_EMG) ? CH_ECG : CH_EMG;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end

            if (timeout_hit) begin
                timeout <= 1'b1;
            end else if (clear_flags) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// ----------------------------------------------------------------------------
// tb_adc_sample_sequencer
// Directed bench for adc_sample_sequencer with a short tick period, a 4-deep
// ring buffer and a DRP responder with a programmable drdy delay.
// ----------------------------------------------------------------------------
module tb_adc_sample_sequencer;

    localparam int CLK_DIV   = 8;
    localparam int BUF_DEPTH = 4;
    localparam int TIMEOUT   = 64;

    logic        clock       = 1'b0;
    logic        reset       = 1'b1;
    logic        enable      = 1'b0;
    logic        clear_flags = 1'b0;
    logic [15:0] drp_do      = '0;
    logic        drp_drdy    = 1'b0;
    logic        drp_den;
    logic        drp_dwe;
    logic [6:0]  drp_daddr;
    logic        adc_wEn;
    logic [11:0] adc_addr;
    logic [31:0] adc_dataIn;
    logic [9:0]  emg_head;
    logic [9:0]  ecg_head;
    logic        busy;
    logic        overrun;
    logic        timeout;

    adc_sample_sequencer #(
        .CLK_DIV   (CLK_DIV),
        .BUF_DEPTH (BUF_DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .clear_flags (clear_flags),
        .drp_den     (drp_den),
        .drp_dwe     (drp_dwe),
        .drp_daddr   (drp_daddr),
        .drp_do      (drp_do),
        .drp_drdy    (drp_drdy),
        .adc_wEn     (adc_wEn),
        .adc_addr    (adc_addr),
        .adc_dataIn  (adc_dataIn),
        .emg_head    (emg_head),
        .ecg_head    (ecg_head),
        .busy        (busy),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // DRP responder: drdy arrives resp_delay cycles after den; 0 = never.
    int          resp_delay = 3;
    logic [15:0] resp_data  = '0;
    int          rd;
    initial begin
        forever begin
            @(negedge clock);
            if (drp_den && resp_delay > 0) begin
                rd = resp_delay;
                repeat (rd) @(negedge clock);
                drp_do   = resp_data;
                drp_drdy = 1'b1;
                @(negedge clock);
                drp_drdy = 1'b0;
            end
        end
    end

    // Continuous protocol observations.
    int   den_cnt   = 0;
    int   wen_cnt   = 0;
    int   zero_viol = 0;
    int   den_viol  = 0;
    int   dwe_viol  = 0;
    logic den_prev  = 1'b0;
    initial begin
        forever begin
            @(negedge clock);
            if (drp_den) den_cnt++;
            if (drp_den && den_prev) den_viol++;
            den_prev = drp_den;
            if (adc_wEn) wen_cnt++;
            else if (adc_addr != '0 || adc_dataIn != '0) zero_viol++;
            if (drp_dwe !== 1'b0) dwe_viol++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_den(output int c, output logic [6:0] a);
        int n;
        c = -1;
        a = '0;
        n = 0;
        while (c < 0 && n < 100) begin
            @(negedge clock);
            n++;
            if (drp_den) begin
                c = cyc;
                a = drp_daddr;
            end
        end
        if (c < 0) check("den_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic wait_wen(output int c, output logic [11:0] wa, output logic [31:0] wd);
        int n;
        c  = -1;
        wa = '0;
        wd = '0;
        n  = 0;
        while (c < 0 && n < 100) begin
            @(negedge clock);
            n++;
            if (adc_wEn) begin
                c  = cyc;
                wa = adc_addr;
                wd = adc_dataIn;
            end
        end
        if (c < 0) check("wen_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic do_txn(input string tag, input logic [6:0] exp_daddr,
                          input logic [11:0] exp_addr, input logic [15:0] din,
                          output int dc);
        int          wc;
        logic [6:0]  a;
        logic [11:0] wa;
        logic [31:0] wd;
        resp_data = din;
        wait_den(dc, a);
        check({tag, "_daddr"}, 32'(a), 32'(exp_daddr));
        wait_wen(wc, wa, wd);
        check({tag, "_addr"}, 32'(wa), 32'(exp_addr));
        check({tag, "_data"}, wd, {20'b0, din[15:4]});
        check({tag, "_lat"}, 32'(wc - dc), 32'(resp_delay + 1));
        @(negedge clock);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int         dc;
        int         dc2;
        int         r;
        int         c0;
        int         w0;
        int         d0;
        logic [6:0] a;

        repeat (3) @(negedge clock);
        check("rst_den",   32'(drp_den), 32'd0);
        check("rst_daddr", 32'(drp_daddr), 32'd0);
        check("rst_wen",   32'(adc_wEn), 32'd0);
        check("rst_addr",  32'(adc_addr), 32'd0);
        check("rst_data",  adc_dataIn, 32'd0);
        check("rst_heads", 32'({emg_head, ecg_head}), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_flags", 32'({overrun, timeout}), 32'd0);

        // Basic EMG then ECG read.
        resp_delay = 3;
        reset  = 1'b0;
        enable = 1'b1;
        c0     = cyc;
        do_txn("t1_emg", 7'h13, 12'h100, 16'hABC0, dc);
        check("t1_first_den", 32'(dc - c0), 32'(CLK_DIV));
        check("t1_emg_head", 32'(emg_head), 32'd1);
        check("t1_ecg_head", 32'(ecg_head), 32'd0);
        do_txn("t1_ecg", 7'h1B, 12'h380, 16'h1234, dc2);
        check("t1_period", 32'(dc2 - dc), 32'(CLK_DIV));
        check("t1_ecg_head2", 32'(ecg_head), 32'd1);

        // Ring-buffer wrap over 9 pairs in total.
        for (int i = 1; i < 9; i++) begin
            do_txn("t2_emg", 7'h13, 12'h100 + 12'(i % BUF_DEPTH), 16'(i * 16 + 5), dc);
            check("t2_emg_head", 32'(emg_head), 32'((i + 1) % BUF_DEPTH));
            do_txn("t2_ecg", 7'h1B, 12'h380 + 12'(i % BUF_DEPTH), 16'(i * 256 + 7), dc);
            check("t2_ecg_head", 32'(ecg_head), 32'((i + 1) % BUF_DEPTH));
        end

        // drdy never returned.
        resp_delay = 0;
        w0 = wen_cnt;
        wait_den(r, a);
        check("t3_daddr", 32'(a), 32'h13);
        repeat (TIMEOUT) @(negedge clock);
        check("t3_no_early_timeout", 32'(timeout), 32'd0);
        @(negedge clock);
        check("t3_timeout_set", 32'(timeout), 32'd1);
        check("t3_overrun_set", 32'(overrun), 32'd1);
        check("t3_no_wen", 32'(wen_cnt - w0), 32'd0);
        check("t3_emg_head", 32'(emg_head), 32'd1);
        check("t3_busy_low", 32'(busy), 32'd0);
        resp_delay  = 3;
        clear_flags = 1'b1;
        @(negedge clock);
        clear_flags = 1'b0;
        check("t3_flags_clear", 32'({overrun, timeout}), 32'd0);
        do_txn("t3_ecg", 7'h1B, 12'h381, 16'h5550, dc);
        check("t3_ecg_den_cycle", 32'(dc - r), 32'd72);
        check("t3_ecg_head", 32'(ecg_head), 32'd2);

        // drdy later than a tick period: dropped tick, no extra den.
        check("t4_overrun_pre", 32'(overrun), 32'd0);
        resp_delay = 12;
        d0 = den_cnt;
        do_txn("t4_emg", 7'h13, 12'h101, 16'h0FF0, dc);
        check("t4_overrun_set", 32'(overrun), 32'd1);
        resp_delay = 3;
        do_txn("t4_ecg", 7'h1B, 12'h382, 16'h7770, dc2);
        check("t4_next_den", 32'(dc2 - dc), 32'd16);
        check("t4_den_count", 32'(den_cnt - d0), 32'd2);
        check("t4_heads", 32'({emg_head, ecg_head}), 32'({10'd2, 10'd3}));

        // Reset while waiting for drdy, with drdy landing the next cycle.
        resp_delay = 2;
        w0 = wen_cnt;
        wait_den(r, a);
        check("t5_daddr", 32'(a), 32'h13);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("t5_busy_async", 32'(busy), 32'd0);
        check("t5_den_async", 32'(drp_den), 32'd0);
        check("t5_heads_async", 32'({emg_head, ecg_head}), 32'd0);
        repeat (3) @(negedge clock);
        check("t5_no_wen", 32'(wen_cnt - w0), 32'd0);
        check("t5_flags", 32'({overrun, timeout}), 32'd0);
        reset = 1'b0;
        c0    = cyc;
        do_txn("t5_emg", 7'h13, 12'h100, 16'h4440, dc);
        check("t5_first_den", 32'(dc - c0), 32'(CLK_DIV));
        check("t5_emg_head", 32'(emg_head), 32'd1);

        // Enable low for 20 cycles mid-period.
        enable = 1'b0;
        d0 = den_cnt;
        repeat (20) @(negedge clock);
        check("t6_no_den", 32'(den_cnt - d0), 32'd0);
        enable = 1'b1;
        c0     = cyc;
        do_txn("t6_ecg", 7'h1B, 12'h380, 16'h9990, dc);
        check("t6_first_den", 32'(dc - c0), 32'(CLK_DIV));
        check("t6_ecg_head", 32'(ecg_head), 32'd1);

        check("zero_when_idle", 32'(zero_viol), 32'd0);
        check("den_single_cycle", 32'(den_viol), 32'd0);
        check("dwe_low", 32'(dwe_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
